// File: rtl/div_16x16_seq_if.sv
// div_16x16_seq_if
// Handshake and operand/result bundle for the sequential divider.
//   master : drives operands (in_valid, a, b, unsign) and out_ready
//   slave  : the divider; drives in_ready and the result fields
// Signals:
//   in_valid/in_ready    operand handshake
//   a, b, unsign         dividend, divisor, 1 = unsigned
//   out_valid/out_ready  result handshake
//   quotient, remainder  results; div_by_zero flags b == 0
interface div_16x16_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             unsign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, unsign, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, unsign, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_16x16_seq.sv
// div_16x16_seq
// Iterative radix-2 non-restoring integer divider (DIV/DIVU/REM/REMU).
// One operation in flight; quotient truncates toward zero, remainder takes
// the sign of the dividend. b == 0 gives quotient all ones, remainder a.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - div_16x16_seq_if.slave (operand/result valid-ready handshakes)
// Optional build macro:
//   DIV_EARLY_EXIT_EN - skip the iterations when b == 0 or |a| < |b|;
//                       result then appears 2 cycles after accept.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// PREP  | form magnitudes and result signs, clear partial remainder
// ITER  | one quotient bit per cycle, WIDTH cycles
// FIX   | restore remainder, apply signs, load outputs
// DONE  | result held until out_ready
module div_16x16_seq #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    div_16x16_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dq;      // dividend in, quotient bits shift in from the right
    logic [WIDTH-1:0] dvs;     // divisor (magnitude after PREP)
    logic [WIDTH:0]   pr;      // partial remainder, one extra bit so add/sub never overflows
    logic [CW-1:0]    cnt;
    logic             uns_q, neg_q, neg_r, dbz;
    logic [WIDTH-1:0] q_out, r_out;
    logic             dbz_out;

    logic [WIDTH:0]   pr_sh, pr_step, pr_fix;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             early;

    always_comb begin
        pr_sh   = {pr[WIDTH-1:0], dq[WIDTH-1]};
        pr_step = pr[WIDTH] ? pr_sh + {1'b0, dvs} : pr_sh - {1'b0, dvs};
        pr_fix  = pr[WIDTH] ? pr + {1'b0, dvs} : pr;
        // In PREP, dq/dvs still hold the raw operands.
        mag_a   = (!uns_q && dq[WIDTH-1])  ? -dq  : dq;
        mag_b   = (!uns_q && dvs[WIDTH-1]) ? -dvs : dvs;
`ifdef DIV_EARLY_EXIT_EN
        early   = (dvs == '0) || (mag_a < mag_b);
`else
        early   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = PREP;
            // Early exit still passes through FIX so it can reuse the sign fix-up.
            PREP: state_nxt = early ? FIX : ITER;
            ITER: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq      <= '0;
            dvs     <= '0;
            pr      <= '0;
            cnt     <= '0;
            uns_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz     <= 1'b0;
            q_out   <= '0;
            r_out   <= '0;
            dbz_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dq    <= bus.a;
                    dvs   <= bus.b;
                    uns_q <= bus.unsign;
                end
                PREP: begin
                    // Early exit: quotient 0 and remainder |a| fall out of FIX unchanged.
                    dq    <= early ? '0 : mag_a;
                    dvs   <= mag_b;
                    pr    <= early ? {1'b0, mag_a} : '0;
                    neg_q <= !uns_q && (dq[WIDTH-1] ^ dvs[WIDTH-1]);
                    neg_r <= !uns_q && dq[WIDTH-1];
                    dbz   <= (dvs == '0);
                    cnt   <= CW'(WIDTH - 1);
                end
                ITER: begin
                    pr  <= pr_step;
                    dq  <= {dq[WIDTH-2:0], ~pr_step[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    q_out   <= dbz ? '1 : (neg_q ? -dq : dq);
                    r_out   <= neg_r ? -pr_fix[WIDTH-1:0] : pr_fix[WIDTH-1:0];
                    dbz_out <= dbz;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dbz_out;
endmodule
